banco_registradores_wb: RTL and testbench

Register file and write-back stage of the multicycle MIPS datapath. It sits directly downstream of the control unit and consumes `regWrite`, `regDst`, `memToReg`, `writeA` and `writeB`. It selects and writes the destination register from ALUOut, MDR, the LUI immediate or PC. It latches the two source operands into the A/B registers that feed the ALU on the next cycle.

---
 rtl/banco_registradores_wb.sv | 87 ++++++++
 tb/tb_banco_registradores_wb.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/banco_registradores_wb.sv
`default_nettype none
// ============================================================================
// Module   : banco_registradores_wb
// Function : MIPS multicycle register file, write-back mux and A/B operand
//            registers. Define REG_BYPASS_EN for write-first A/B capture.
// Revision : 1.0
// ============================================================================
module banco_registradores_wb #(
  parameter logic [31:0] SP_RESET_VALUE = 32'd227,
  parameter int          NREGS          = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        regWrite,
  input  logic        regDst,
  input  logic [2:0]  memToReg,
  input  logic        writeA,
  input  logic        writeB,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm16,
  input  logic [31:0] aluOut,
  input  logic [31:0] mdr,
  input  logic [31:0] pc,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [31:0] wbData,
  output logic [4:0]  wbAddr
);

  localparam int C_SP_IDX = 29;

  logic [31:0] r_regs [NREGS];
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] w_wbData;
  logic [4:0]  w_wbAddr;
  logic        w_doWrite;
  logic [31:0] w_rsData;
  logic [31:0] w_rtData;

  assign w_wbAddr  = regDst ? rd : rt;
  assign w_doWrite = regWrite && (w_wbAddr != 5'd0);

  always_comb begin
    w_wbData = 32'h0000_0000;
    case (memToReg)
      3'b000:  w_wbData = aluOut;
      3'b001:  w_wbData = mdr;
      3'b010:  w_wbData = {imm16, 16'h0000};
      3'b011:  w_wbData = pc;
      default: w_wbData = 32'h0000_0000;
    endcase
  end

  // Register 0 reads as zero regardless of array contents, so it is never bypassed.
  always_comb begin
    w_rsData = (rs == 5'd0) ? 32'h0 : r_regs[rs];
    w_rtData = (rt == 5'd0) ? 32'h0 : r_regs[rt];
`ifdef REG_BYPASS_EN
    if (w_doWrite && (w_wbAddr == rs)) w_rsData = w_wbData;
    if (w_doWrite && (w_wbAddr == rt)) w_rtData = w_wbData;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= (i == C_SP_IDX) ? SP_RESET_VALUE : 32'h0;
      end
      r_a <= 32'h0;
      r_b <= 32'h0;
    end else begin
      if (w_doWrite) r_regs[w_wbAddr] <= w_wbData;
      if (writeA)    r_a <= w_rsData;
      if (writeB)    r_b <= w_rtData;
    end
  end

  assign a      = r_a;
  assign b      = r_b;
  assign wbData = w_wbData;
  assign wbAddr = w_wbAddr;

endmodule
`default_nettype wire

// File: tb/tb_banco_registradores_wb.sv
`default_nettype none
// Testbench for banco_registradores_wb: directed vector table, reset sequence
// and randomized traffic checked against an array-based reference model.
module tb_banco_registradores_wb;

`ifdef REG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        regWrite = 0, regDst = 0, writeA = 0, writeB = 0;
  logic [2:0]  memToReg = 0;
  logic [4:0]  rs = 0, rt = 0, rd = 0;
  logic [15:0] imm16 = 0;
  logic [31:0] aluOut = 0, mdr = 0, pc = 0;
  logic [31:0] a, b, wbData;
  logic [4:0]  wbAddr;

  int nvec = 0;
  int nerr = 0;

  banco_registradores_wb dut (
    .clk(clk), .reset(reset), .regWrite(regWrite), .regDst(regDst),
    .memToReg(memToReg), .writeA(writeA), .writeB(writeB),
    .rs(rs), .rt(rt), .rd(rd), .imm16(imm16),
    .aluOut(aluOut), .mdr(mdr), .pc(pc),
    .a(a), .b(b), .wbData(wbData), .wbAddr(wbAddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw, rdst;
    logic [2:0]  mt;
    logic        wa, wb;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] alu, mdr, pc;
    logic [4:0]  expAddr;
    logic [31:0] expData, expA, expB;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rw_i, input logic rdst_i, input logic [2:0] mt_i,
                       input logic wa_i, input logic wb_i, input logic [4:0] rs_i,
                       input logic [4:0] rt_i, input logic [4:0] rd_i, input logic [15:0] imm_i,
                       input logic [31:0] alu_i, input logic [31:0] mdr_i, input logic [31:0] pc_i);
    regWrite = rw_i; regDst = rdst_i; memToReg = mt_i; writeA = wa_i; writeB = wb_i;
    rs = rs_i; rt = rt_i; rd = rd_i; imm16 = imm_i; aluOut = alu_i; mdr = mdr_i; pc = pc_i;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  // Reference model
  logic [31:0] mRegs [32];
  logic [31:0] mA, mB;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mRegs[i] = (i == 29) ? 32'd227 : 32'h0;
    mA = 0; mB = 0;
  endtask

  function automatic logic [31:0] sel_data(input logic [2:0] mt, input logic [15:0] imm,
                                           input logic [31:0] alu, input logic [31:0] md,
                                           input logic [31:0] p);
    if (mt >= 3'd4) return 32'h0;
    if (mt == 3'd0) return alu;
    if (mt == 3'd1) return md;
    if (mt == 3'd2) return {imm, 16'h0};
    return p;
  endfunction

  initial begin
    vecs[0]  = '{1,1,3'd0,0,0, 5'd0, 5'd0, 5'd8, 16'h0, 32'h15, 32'h0, 32'h0, 5'd8, 32'h15, 32'd227, 32'h0};
    vecs[1]  = '{0,0,3'd0,1,0, 5'd8, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h15, 32'h0};
    vecs[2]  = '{1,0,3'd1,0,0, 5'd0, 5'd9, 5'd0, 16'h0, 32'h0, 32'hDEADBEEF, 32'h0, 5'd9, 32'hDEADBEEF, 32'h15, 32'h0};
    vecs[3]  = '{0,0,3'd1,0,1, 5'd0, 5'd9, 5'd0, 16'h0, 32'h0, 32'hDEADBEEF, 32'h0, 5'd9, 32'hDEADBEEF, 32'h15, 32'hDEADBEEF};
    vecs[4]  = '{1,0,3'd2,0,0, 5'd0, 5'd10, 5'd0, 16'h1234, 32'h0, 32'h0, 32'h0, 5'd10, 32'h12340000, 32'h15, 32'hDEADBEEF};
    vecs[5]  = '{0,0,3'd0,1,0, 5'd10, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h12340000, 32'hDEADBEEF};
    vecs[6]  = '{1,1,3'd0,0,0, 5'd0, 5'd0, 5'd0, 16'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 32'h12340000, 32'hDEADBEEF};
    vecs[7]  = '{0,0,3'd0,1,1, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0};
    vecs[8]  = '{1,1,3'd3,0,0, 5'd0, 5'd0, 5'd11, 16'h0, 32'h0, 32'h0, 32'h400, 5'd11, 32'h400, 32'h0, 32'h0};
    vecs[9]  = '{0,0,3'd0,1,1, 5'd11, 5'd8, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0, 5'd8, 32'h0, 32'h400, 32'h15};
    vecs[10] = '{1,1,3'd0,0,0, 5'd0, 5'd0, 5'd13, 16'h0, 32'h77, 32'h0, 32'h0, 5'd13, 32'h77, 32'h400, 32'h15};
    vecs[11] = '{1,1,3'd5,0,0, 5'd0, 5'd0, 5'd13, 16'hABCD, 32'h5, 32'h1, 32'h2, 5'd13, 32'h0, 32'h400, 32'h15};
    vecs[12] = '{0,0,3'd0,1,0, 5'd13, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h15};
    vecs[13] = '{1,1,3'd0,0,0, 5'd0, 5'd0, 5'd12, 16'h0, 32'h5, 32'h0, 32'h0, 5'd12, 32'h5, 32'h0, 32'h15};
    vecs[14] = '{1,1,3'd0,1,0, 5'd12, 5'd0, 5'd12, 16'h0, 32'h7, 32'h0, 32'h0, 5'd12, 32'h7, BYP ? 32'h7 : 32'h5, 32'h15};
    vecs[15] = '{0,0,3'd0,1,0, 5'd12, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h7, 32'h15};
    for (int i = 16; i < 20; i++)
      vecs[i] = '{1,1,3'd0,0,0, 5'd8, 5'd8, 5'd8, 16'h0, 32'h99, 32'h0, 32'h0, 5'd8, 32'h99, 32'h7, 32'h15};
    vecs[20] = '{0,0,3'd0,0,1, 5'd0, 5'd8, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0, 5'd8, 32'h0, 32'h7, 32'h99};

    // Reset sequence
    #2;
    chk("reset_a", a, 32'h0);
    chk("reset_b", b, 32'h0);
    edge_step();
    reset = 1'b0;
    drive(1,1,3'd0,1,0, 5'd29, 5'd0, 5'd5, 16'h0, 32'h55, 32'h0, 32'h0);
    edge_step();
    chk("load_sp_a", a, 32'd227);
    drive(0,0,3'd0,0,1, 5'd0, 5'd5, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0);
    edge_step();
    chk("load_r5_b", b, 32'h55);
    drive(1,1,3'd0,1,1, 5'd29, 5'd5, 5'd5, 16'h0, 32'h66, 32'h0, 32'h0);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_a", a, 32'h0);
    chk("async_reset_b", b, 32'h0);
    edge_step();
    chk("reset_override_a", a, 32'h0);
    chk("reset_override_b", b, 32'h0);
    #2 reset = 1'b0;
    drive(0,0,3'd0,1,1, 5'd29, 5'd5, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0);
    edge_step();
    chk("post_reset_a_sp", a, 32'd227);
    chk("post_reset_b_r5", b, 32'h0);

    // Directed vector table
    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].rw, vecs[i].rdst, vecs[i].mt, vecs[i].wa, vecs[i].wb, vecs[i].rs,
            vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].alu, vecs[i].mdr, vecs[i].pc);
      #1;
      chk($sformatf("v%0d_wbAddr", i), {27'h0, wbAddr}, {27'h0, vecs[i].expAddr});
      chk($sformatf("v%0d_wbData", i), wbData, vecs[i].expData);
      edge_step();
      chk($sformatf("v%0d_a", i), a, vecs[i].expA);
      chk($sformatf("v%0d_b", i), b, vecs[i].expB);
    end

    // Randomized traffic against the reference model
    drive(0,0,3'd0,0,0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0);
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      logic [4:0]  eAddr;
      logic [31:0] eData, nA, nB;
      logic        doW;
      if ($urandom_range(0, 59) == 0) begin
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("rand_async_reset_a", a, 32'h0);
        #1 reset = 1'b0;
      end
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
            16'($urandom), 32'($urandom), 32'($urandom), 32'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        rs = 5'($urandom_range(0, 31)); rt = 5'($urandom_range(0, 31)); rd = 5'($urandom_range(0, 31));
      end
      eAddr = regDst ? rd : rt;
      eData = sel_data(memToReg, imm16, aluOut, mdr, pc);
      doW   = regWrite && (eAddr != 0);
      nA = mA; nB = mB;
      if (writeA) nA = (rs == 0) ? 32'h0 : ((BYP && doW && eAddr == rs) ? eData : mRegs[rs]);
      if (writeB) nB = (rt == 0) ? 32'h0 : ((BYP && doW && eAddr == rt) ? eData : mRegs[rt]);
      if (doW) mRegs[eAddr] = eData;
      mA = nA; mB = nB;
      #1;
      chk("rand_wbAddr", {27'h0, wbAddr}, {27'h0, eAddr});
      chk("rand_wbData", wbData, eData);
      edge_step();
      chk("rand_a", a, mA);
      chk("rand_b", b, mB);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
